// File: rtl/debounce_edge.sv
// Glitch filter for an already-synchronized level: debounced y plus one-cycle rise/fall strobes.
// Optional rising-edge event counter built when DEBOUNCE_EVCNT_EN is defined.
module debounce_edge #(
    parameter logic        P_DEFVAL = 1'b0,
    parameter int unsigned P_CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a,
    input  logic [P_CNT_W-1:0] thresh,
    output logic               y,
    output logic               rise,
    output logic               fall,
    output logic               busy,
    input  logic               ev_clr,
    output logic [31:0]        ev_cnt
);

    typedef enum logic {STABLE, PEND} state_t;

    state_t             state;
    logic [P_CNT_W-1:0] cnt;
    logic [P_CNT_W-1:0] thr_q;
    logic [P_CNT_W-1:0] thr_eff;
    logic [P_CNT_W-1:0] cnt_inc;

    always_comb begin
        thr_eff = (thresh == '0) ? P_CNT_W'(1) : thresh;
        cnt_inc = cnt + P_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STABLE;
            y     <= P_DEFVAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
            thr_q <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE: begin
                    if (a != y) begin
                        if (thr_eff == P_CNT_W'(1)) begin
                            y    <= a;
                            rise <= a;
                            fall <= ~a;
                        end else begin
                            state <= PEND;
                            busy  <= 1'b1;
                            cnt   <= P_CNT_W'(1);
                            thr_q <= thr_eff;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                PEND: begin
                    // thr_q was captured on entry; thresh changes here are ignored
                    if (a == y) begin
                        state <= STABLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt_inc == thr_q) begin
                        y     <= a;
                        rise  <= a;
                        fall  <= ~a;
                        state <= STABLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= STABLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EVCNT_EN
    logic [31:0] ev_q;

    // Counts the registered rise strobe; a clear in the same cycle keeps that rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_q <= '0;
        end else if (ev_clr) begin
            ev_q <= {31'b0, rise};
        end else begin
            ev_q <= ev_q + {31'b0, rise};
        end
    end

    assign ev_cnt = ev_q;
`else
    logic unused_ev_clr;
    assign unused_ev_clr = ev_clr;
    assign ev_cnt        = '0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed test-plan steps followed by random stimulus,
// all compared against a run-length reference model.
module tb_debounce_edge;

    localparam int unsigned W   = 16;
    localparam logic        DEF = 1'b1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          a      = 1'b0;
    logic          ev_clr = 1'b0;
    logic [W-1:0]  thresh = '0;
    logic          y, rise, fall, busy;
    logic [31:0]   ev_cnt;

    debounce_edge #(.P_DEFVAL(DEF), .P_CNT_W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .thresh (thresh),
        .y      (y),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy),
        .ev_clr (ev_clr),
        .ev_cnt (ev_cnt)
    );

    always #5 clk = ~clk;

    // Reference: y flips once a run of mismatching samples reaches the threshold
    // latched at the start of that run.
    bit          m_y    = DEF;
    bit          m_rise = 1'b0;
    bit          m_fall = 1'b0;
    int unsigned m_run  = 0;
    int unsigned m_thr  = 1;
    logic [31:0] m_ev   = '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_y = DEF; m_rise = 0; m_fall = 0; m_run = 0; m_ev = '0;
        end else begin
`ifdef DEBOUNCE_EVCNT_EN
            m_ev = ev_clr ? {31'b0, m_rise} : m_ev + {31'b0, m_rise};
`else
            m_ev = '0;
`endif
            m_rise = 0;
            m_fall = 0;
            if (a == m_y) begin
                m_run = 0;
            end else begin
                if (m_run == 0) m_thr = (thresh == 0) ? 1 : int'(thresh);
                m_run++;
                if (m_run == m_thr) begin
                    m_y    = a;
                    m_rise = a;
                    m_fall = !a;
                    m_run  = 0;
                end
            end
        end
    endtask

    task automatic step(input bit ai, input int th, input bit clr, input bit rn);
        a      = ai;
        thresh = W'(th);
        ev_clr = clr;
        rst_n  = rn;
        @(posedge clk);
        model_edge();
        #1;
        chk("y",      {31'b0, y},    {31'b0, m_y});
        chk("rise",   {31'b0, rise}, {31'b0, m_rise});
        chk("fall",   {31'b0, fall}, {31'b0, m_fall});
        chk("busy",   {31'b0, busy}, {31'b0, m_run != 0});
        chk("ev_cnt", ev_cnt,        m_ev);
        chk("rise_and_fall", {31'b0, rise & fall}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset held with a toggling; release with a matching y produces no strobe
        for (int i = 0; i < 5; i++) step(i[0], 4, 0, 0);
        step(1, 4, 0, 1);
        chk("reset_release_y", {31'b0, y}, 32'd1);

        // Bring y low, then clean rise with thresh=4
        step(0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 4, 0, 1);
        chk("clean_rise_y", {31'b0, y}, 32'd1);

        // Glitch of 3 samples with thresh=4 is rejected
        step(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 4, 0, 1);
        step(0, 4, 0, 1);
        step(0, 4, 0, 1);
        chk("glitch_y", {31'b0, y}, 32'd0);

        // thresh=0 and thresh=1 both act on the first sampling edge
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 1, 0, 1);
        step(0, 1, 0, 1);

        // thresh lowered mid-qualification does not shorten the transition
        step(1, 8, 0, 1);
        step(1, 8, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 2, 0, 1);
        chk("midpend_not_yet", {31'b0, y}, 32'd0);
        step(1, 2, 0, 1);
        chk("midpend_y", {31'b0, y}, 32'd1);

        // Three qualified rises, then a clear coinciding with a fourth rise strobe
        step(0, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 2, 0, 1);
            step(1, 2, 0, 1);
            step(0, 1, 0, 1);
        end
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        step(0, 1, 0, 1);

`ifdef DEBOUNCE_EVCNT_EN
        // Preload near wrap, then one rise takes the count through zero
        force dut.ev_q = 32'hFFFF_FFFF;
        #1;
        release dut.ev_q;
        m_ev = 32'hFFFF_FFFF;
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        chk("ev_wrap", ev_cnt, 32'd0);
        step(0, 1, 0, 1);
`endif

        // Random stimulus with sticky input, small thresholds, sparse clears and resets
        for (int i = 0; i < 600; i++) begin
            bit ai;
            ai = ($urandom_range(0, 3) == 0) ? ~a : a;
            step(ai, int'($urandom_range(0, 6)), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Conditioning stage placed directly downstream of the two-flip-flop synchronizer.
- Takes an already-synchronized single-bit level, for example a front-panel input, a discriminator or trigger line, or a slow external status line.
- Rejects glitches shorter than a programmable number of clk cycles.
- Produces a clean debounced level plus one-cycle rise and fall strobes for the control and counting logic.

Parameters:
- P_DEFVAL, 1'b0: reset value of the debounced level y. It must match the synchronizer's P_DEFVAL.
- P_CNT_W, 16: width of the debounce counter and of the thresh port.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- a  input  1  synchronized input level. It comes from the synchronizer output; no further metastability protection is done here.
- thresh  input  P_CNT_W  number of consecutive mismatching samples required before y changes. A value of 0 is treated as 1.
- y  output  1  debounced level.
- rise  output  1  one-cycle pulse when y goes 0->1.
- fall  output  1  one-cycle pulse when y goes 1->0.
- busy  output  1  high while a transition is being qualified (state PEND).
- ev_clr  input  1  clear for the event counter (see Optional Feature).
- ev_cnt  output  32  rising-edge event count (see Optional Feature).

Behaviour:
- Reset, sampled on posedge clk while rst_n==0:
  - y=P_DEFVAL; rise=0; fall=0; busy=0; cnt=0; ev_cnt=0; state=STABLE.
  - Reset overrides everything, including reset asserted mid-PEND; no strobe is issued.
- All outputs are registered.
- thr_eff = (thresh==0) ? 1 : thresh.
- thr_eff is latched into thr_q on entry to PEND. Changes to thresh during PEND do not affect the transition already in progress.
- FSM, evaluated each posedge:
  - STABLE, a==y: stay; cnt=0.
  - STABLE, a!=y, thr_eff==1:
    - y<=a; pulse rise or fall; stay in STABLE.
    - Latency: y changes on the first edge that samples the mismatch.
  - STABLE, a!=y, thr_eff>1: go to PEND; cnt<=1; thr_q<=thr_eff.
  - PEND, a==y: glitch rejected; go to STABLE; cnt<=0; no strobe; y unchanged.
  - PEND, a!=y, cnt+1==thr_q: y<=a; pulse rise or fall; go to STABLE; cnt<=0.
  - PEND, a!=y, otherwise: cnt<=cnt+1.
- General latency: y updates on the thr_eff-th consecutive edge that samples a!=y.
- rise and fall:
  - Each is high for exactly one cycle, coincident with the cycle y first shows its new value.
  - They are never high together.
- busy = (state==PEND).
- cnt is P_CNT_W bits. The compare uses an exact match against thr_q, which is at most 2^P_CNT_W-1, so cnt never wraps.
- Back-to-back transitions: after a strobe, a new mismatch can be accepted on the very next edge. The minimum spacing between strobes is thr_eff cycles.

Optional Feature:
- Macro: DEBOUNCE_EVCNT_EN.
- Defined:
  - ev_cnt is a 32-bit counter that increments on every cycle rise is asserted and wraps 0xFFFFFFFF->0.
  - ev_clr sets ev_cnt to 0 on the next edge.
  - If ev_clr and rise occur in the same cycle, ev_cnt becomes 1.
- Not defined:
  - The counter logic is not built and ev_cnt is tied to 0.
  - ev_clr is ignored.
  - The port list is identical in both builds.

Test Plan:
- Reset and defaults: hold rst_n=0 for 5 cycles with a toggling, P_DEFVAL=1 -> y=1, rise=fall=busy=0 throughout. Release reset with a=1 -> no strobe.
- Clean rise: thresh=4, a held 0->1 -> busy high for 3 cycles; y=1 and rise=1 on the 4th edge sampling a=1; rise low one cycle later.
- Glitch rejection: thresh=4, a=1 for 3 cycles then back to 0 -> y stays 0; no rise/fall; busy drops the cycle after a returns to 0.
- thresh=0 and thresh=1: a 0->1 -> y=1 with a rise pulse on the first sampling edge in both cases. A 1-cycle pulse on a produces a rise then a fall on consecutive cycles.
- Threshold change mid-PEND: thresh=8, after 2 mismatching cycles set thresh=2 -> y still changes on the 8th edge.
- Event counter (DEBOUNCE_EVCNT_EN defined): 3 qualified rising edges -> ev_cnt=3. ev_clr coincident with a 4th rise -> ev_cnt=1. Preload near wrap (force or long run) 0xFFFFFFFF plus 1 rise -> 0. Macro undefined -> ev_cnt=0 always.
